// File: rtl/fir_ram_pkg.sv
// Shared types and default sizing for the FIR_RAM MAC datapath.
package fir_ram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_NTAPS  = 8;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        MAC,
        OUT
    } fir_state_e;

    // Full-precision sum of NTAPS products never needs more than log2(NTAPS) guard bits.
    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
module fir_ram_sdp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_ram_mac_core.sv
// Time-multiplexed FIR: one sample in, NTAPS MACs against RAM-held coefficients and history, one result out.
//
// state | meaning
// CLEAR | zero history RAM, one entry per cycle
// IDLE  | s_ready high, waiting for a sample
// MAC   | issue NTAPS reads, accumulate each product one cycle later
// OUT   | hold result until m_ready
module fir_ram_mac_core
    import fir_ram_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEF_W  = DEF_COEF_W,
    parameter int NTAPS   = DEF_NTAPS,
    localparam int TAP_AW = $clog2(NTAPS),
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              coef_we,
    input  logic [TAP_AW-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              coef_err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic              busy
);

    localparam int CNT_W  = TAP_AW + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(NTAPS);

    fir_state_e state, state_nxt;

    logic [CNT_W-1:0]         cnt;
    logic [TAP_AW-1:0]        wr_ptr;
    logic [TAP_AW-1:0]        base;
    logic signed [ACC_W-1:0]  acc;
    logic                     rd_vld;
    logic                     coef_ok;
    logic                     coef_wr;
    logic                     hist_we;
    logic [TAP_AW-1:0]        hist_waddr;
    logic [DATA_W-1:0]        hist_wdata;
    logic [TAP_AW-1:0]        rd_k;
    logic [TAP_AW-1:0]        hist_raddr;
    logic [COEF_W-1:0]        coef_rdata;
    logic [DATA_W-1:0]        hist_rdata;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] hist_ext;
    logic signed [PROD_W-1:0] prod;

    assign rd_k       = cnt[TAP_AW-1:0];
    assign hist_raddr = base - rd_k;
    assign coef_wr    = coef_we && coef_ok && !ARESET;
    assign coef_ext   = PROD_W'($signed(coef_rdata));
    assign hist_ext   = PROD_W'($signed(hist_rdata));
    assign prod       = coef_ext * hist_ext;
    assign m_data     = acc;

    fir_ram_sdp #(.WIDTH(COEF_W), .DEPTH(NTAPS)) u_coef_ram (
        .clk   (ACLK),
        .we    (coef_wr),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (rd_k),
        .rdata (coef_rdata)
    );

    fir_ram_sdp #(.WIDTH(DATA_W), .DEPTH(NTAPS)) u_hist_ram (
        .clk   (ACLK),
        .we    (hist_we),
        .waddr (hist_waddr),
        .wdata (hist_wdata),
        .raddr (hist_raddr),
        .rdata (hist_rdata)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b1;
        coef_ok    = 1'b0;
        hist_we    = 1'b0;
        hist_waddr = wr_ptr;
        hist_wdata = s_data;
        case (state)
            CLEAR: begin
                hist_we    = 1'b1;
                hist_waddr = rd_k;
                hist_wdata = '0;
                if (cnt == CLR_LAST) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                coef_ok = 1'b1;
                if (s_valid) begin
                    hist_we   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (cnt == MAC_LAST) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                coef_ok = 1'b1;
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Read for tap k is issued while cnt == k; its product lands in acc one cycle after the RAM output.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            base     <= '0;
            acc      <= '0;
            rd_vld   <= 1'b0;
            coef_err <= 1'b0;
        end else begin
            coef_err <= coef_we && !coef_ok;
            rd_vld   <= (state == MAC) && (cnt < MAC_LAST);
            if (rd_vld) begin
                acc <= acc + ACC_W'(prod);
            end
            case (state)
                CLEAR: cnt <= (cnt == CLR_LAST) ? '0 : cnt + 1'b1;
                IDLE: begin
                    if (s_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        base   <= wr_ptr;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MAC: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
